ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Sequences the configuration-chain (ccff) load for one programmable tile, e.g. an 8-subtile IO grid.
- Takes bitstream words over a valid/ready stream, serialises them onto ccff_head one bit per enabled prog_clk cycle, and drives a shift enable that feeds the tile's prog_clk clock gate.
- Signals completion, and optionally verifies the loaded chain non-destructively via ccff_tail.
- Sits between the bitstream source and the tile's ccff_head/ccff_tail pins.

Parameters:
- CHAIN_LEN, 8, number of config flops in the chain (total bits to shift); must be ≥1.
- WORD_W, 8, width of cfg_data words; must be ≥1.

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; ignored unless IDLE.
- abort  input  1  returns to IDLE from any state next cycle.
- cfg_data  input  WORD_W  bitstream word, LSB shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  word accepted when cfg_valid & cfg_ready.
- ccff_head  output  1  serial bit into chain.
- ccff_tail  input  1  serial bit out of chain.
- ccff_shift_en  output  1  chain shifts on the prog_clk edge where this is 1.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at load (and verify) completion.
- err  output  1  sticky verify mismatch; cleared on accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; shift register 0.
- Chain contents after a reset are undefined; re-load required.
- State IDLE: start=1 → FETCH; clears err; bits_left ← CHAIN_LEN.
- State FETCH:
  - cfg_ready=1, ccff_shift_en=0, so the chain holds through source stalls.
  - On handshake: sreg ← cfg_data; word_left ← min(WORD_W, bits_left); → SHIFT.
- State SHIFT:
  - ccff_shift_en=1; ccff_head=sreg[0] (registered, glitch-free).
  - Each cycle: sreg shifts right by 1; word_left and bits_left decrement.
  - When bits_left reaches 0 → DONE (or VERIFY when feature enabled).
  - Else, when word_left reaches 0 → FETCH.
- Partial last word: upper unused bits are discarded. Words consumed = ceil(CHAIN_LEN/WORD_W).
- Minimum latency: start → first shift_en is 2 cycles. SHIFT runs exactly CHAIN_LEN enabled cycles, excluding stalls.
- State DONE: done=1 for one cycle → IDLE.
- abort: → IDLE next cycle; shift_en drops in that cycle; partially fetched word is dropped; no done pulse; err unchanged.
- Simultaneous abort and start in IDLE: abort wins; stay IDLE.
- start while busy: ignored.
- cfg_valid outside FETCH: no effect (cfg_ready=0).
- Counter widths: $clog2(CHAIN_LEN+1) and $clog2(WORD_W+1); no wrap is reachable.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- With it:
  - During SHIFT, a CRC-8 (poly 0x07, init 0x00) runs over every bit driven on ccff_head.
  - After SHIFT, state VERIFY runs CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail (recirculation keeps the chain contents intact).
  - A second CRC-8 runs over ccff_tail.
  - At the end: err ← (crc_load != crc_tail); then DONE.
- Without it: no VERIFY state and no CRC logic; err is tied 0.

Decomposition:
- Shared package ccff_pkg holds:
  - state enum: IDLE, FETCH, SHIFT, VERIFY, DONE.
  - CRC8_POLY constant = 8'h07.
  - function crc8_step(crc, bit).
- One natural sub-module: ccff_crc8, a serial CRC-8 with clear and enable, instanced twice under the macro.

Test Plan:
- CHAIN_LEN=8, WORD_W=8: start, cfg_data=0xA5 → ccff_head over 8 enabled cycles = 1,0,1,0,0,1,0,1; then done pulse; 8-flop chain model holds 0xA5.
- CHAIN_LEN=12, WORD_W=8: words 0x3C then 0xF9, with cfg_valid delayed 5 cycles between them → shift_en low during the gap; second word contributes bits 1,0,0,1 only; exactly 12 enabled cycles; done once.
- Abort after 3 shifted bits → busy=0 next cycle, shift_en=0, no done; a following start loads 0xFF cleanly.
- pReset_n asserted mid-SHIFT → all outputs 0 immediately; after release, start + 0x5A loads correctly.
- CCFF_READBACK_EN, chain model correct → after 16 enabled cycles done=1, err=0, chain still 0xA5.
- CCFF_READBACK_EN, chain model with one stuck-at-0 flop → err=1; err stays 1 until the next start.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and CRC-8 helper for the ccff chain loader.
package ccff_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4
    } ccff_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One serial CRC-8 step, MSB-first feedback.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        crc8_step = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_crc8.sv
// Serial CRC-8 accumulator with synchronous clear and bit enable.
module ccff_crc8
    import ccff_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: clear wins over accumulate.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = crc8_step(crc_q, din);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises a bitstream onto a tile's ccff chain, LSB first, one bit per enabled prog_clk.
// Define CCFF_READBACK_EN to add a non-destructive CRC readback of the chain via ccff_tail.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BL_W = $clog2(CHAIN_LEN + 1);
    localparam int WL_W = $clog2(WORD_W + 1);
    localparam logic [BL_W-1:0] BITS_ALL = BL_W'(CHAIN_LEN);
    localparam logic [WL_W-1:0] WORD_ALL = WL_W'(WORD_W);
    localparam logic [BL_W-1:0] BL_ONE   = BL_W'(1);
    localparam logic [WL_W-1:0] WL_ONE   = WL_W'(1);

    ccff_state_e       state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [WL_W-1:0]   word_left_q, word_left_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              shift_en_q, shift_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef CCFF_READBACK_EN
    logic       err_q, err_d;
    logic       crc_clr_s;
    logic [7:0] crc_load_s;
    logic [7:0] crc_tail_s;
`else
    logic       tail_unused_s;
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bits_left_d = bits_left_q;
        word_left_d = word_left_q;
`ifdef CCFF_READBACK_EN
        err_d       = err_q;
`endif
        if (abort) begin
            state_d     = IDLE;
            sreg_d      = '0;
            bits_left_d = '0;
            word_left_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = FETCH;
                        bits_left_d = BITS_ALL;
`ifdef CCFF_READBACK_EN
                        err_d       = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                FETCH: begin
                    if (cfg_valid) begin
                        sreg_d      = cfg_data;
                        word_left_d = (int'(bits_left_q) < WORD_W) ? WL_W'(bits_left_q) : WORD_ALL;
                        state_d     = SHIFT;
                    end else begin
                        state_d = FETCH;
                    end
                end
                SHIFT: begin
                    sreg_d      = sreg_q >> 1'b1;
                    bits_left_d = bits_left_q - BL_ONE;
                    word_left_d = word_left_q - WL_ONE;
                    if (bits_left_q == BL_ONE) begin
                        // Drop the unused upper bits of a partial last word.
                        sreg_d      = '0;
                        word_left_d = '0;
`ifdef CCFF_READBACK_EN
                        state_d     = VERIFY;
                        bits_left_d = BITS_ALL;
`else
                        state_d     = DONE;
`endif
                    end else if (word_left_q == WL_ONE) begin
                        state_d = FETCH;
                    end else begin
                        state_d = SHIFT;
                    end
                end
`ifdef CCFF_READBACK_EN
                VERIFY: begin
                    bits_left_d = bits_left_q - BL_ONE;
                    if (bits_left_q == BL_ONE) begin
                        // Fold in the final tail bit still in flight this cycle.
                        state_d = DONE;
                        err_d   = (crc_load_s != crc8_step(crc_tail_s, ccff_tail));
                    end else begin
                        state_d = VERIFY;
                    end
                end
`endif
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        cfg_ready_d = (state_d == FETCH);
        shift_en_d  = (state_d == SHIFT) || (state_d == VERIFY);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            bits_left_q <= '0;
            word_left_q <= '0;
            cfg_ready_q <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bits_left_q <= bits_left_d;
            word_left_q <= word_left_d;
            cfg_ready_q <= cfg_ready_d;
            shift_en_q  <= shift_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef CCFF_READBACK_EN
    // Verify error flag, sticky until the next accepted start.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign crc_clr_s = (state_q == IDLE) && start && !abort;

    ccff_crc8 u_crc_load (
        .clk   (prog_clk),
        .rst_n (pReset_n),
        .clr   (crc_clr_s),
        .en    (state_q == SHIFT),
        .din   (sreg_q[0]),
        .crc   (crc_load_s)
    );

    ccff_crc8 u_crc_tail (
        .clk   (prog_clk),
        .rst_n (pReset_n),
        .clr   (crc_clr_s),
        .en    (state_q == VERIFY),
        .din   (ccff_tail),
        .crc   (crc_tail_s)
    );

    // Recirculate tail to head during readback so the chain keeps its contents.
    assign ccff_head = (state_q == VERIFY) ? ccff_tail : sreg_q[0];
    assign err       = err_q;
`else
    assign tail_unused_s = ccff_tail;
    assign ccff_head     = sreg_q[0];
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader with a behavioural ccff chain model.
module tb_ccff_chain_loader;

    localparam int CL = 12;
    localparam int WW = 8;
    localparam int NW = (CL + WW - 1) / WW;

    typedef struct packed {
        logic is_done;
        logic val;
    } exp_t;

    logic          prog_clk = 1'b0;
    logic          pReset_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] cfg_data = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_tail;
    logic          ccff_shift_en;
    logic          busy;
    logic          done;
    logic          err;

    logic [CL-1:0] chain_m = '0;
    logic [CL-1:0] stuck_m = '0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_bad = 0;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 prog_clk = ~prog_clk;

    // Tile chain model: head enters bit 0, tail is the top bit; stuck_m forces flops to 0.
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain_m <= {chain_m[CL-2:0], ccff_head} & ~stuck_m;
        end
    end
    assign ccff_tail = chain_m[CL-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: every enabled shift cycle and every done pulse consumes one expected item.
    always @(negedge prog_clk) begin
        if (pReset_n && ccff_shift_en) begin
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL shift_count: unexpected shift cycle, head=%0b (t=%0t)", ccff_head, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("ccff_head", 32'(ccff_head), 32'(mon_e.val));
            end
        end
        if (pReset_n && done) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_timing: done with %0d items still expected (t=%0t)", exp_q.size(), $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("err_at_done", 32'(err), 32'(mon_e.val));
            end
        end
    end

    // Tail stream a chain of CL flops would return on readback after loading stream.
    function automatic logic [CL-1:0] sim_tail(input logic [CL-1:0] stream, input int k);
        logic [CL-1:0] c;
        logic [CL-1:0] ts;
        c  = '0;
        ts = '0;
        for (int i = 0; i < CL; i++) begin
            c = {c[CL-2:0], stream[i]};
            if (k >= 0) c[k] = 1'b0;
        end
        for (int j = 0; j < CL; j++) begin
            ts[j] = c[CL-1];
            c = {c[CL-2:0], c[CL-1]};
            if (k >= 0) c[k] = 1'b0;
        end
        return ts;
    endfunction

    task automatic feed_word(input logic [WW-1:0] w);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_data  = w;
        while (!cfg_ready && n < 400) begin
            @(negedge prog_clk);
            n++;
        end
        check("handshake_timeout", 32'(cfg_ready), 32'd1);
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        cfg_data  = $urandom;
    endtask

    task automatic run_load(input logic [CL-1:0] stream, input int gap, input bit pre_valid,
                            input bit stray_start, input int stuck_k);
        logic [WW-1:0] w [NW];
        logic [CL-1:0] ts;
        logic [CL-1:0] ec;
        int            first;
        int            n;
        int            g;
        for (int i = 0; i < NW; i++) begin
            w[i] = WW'($urandom);
            for (int b = 0; b < WW; b++) begin
                if (i * WW + b < CL) w[i][b] = stream[i * WW + b];
            end
        end
        for (int i = 0; i < CL; i++) exp_q.push_back('{1'b0, stream[i]});
`ifdef CCFF_READBACK_EN
        ts = sim_tail(stream, stuck_k);
        for (int j = 0; j < CL; j++) exp_q.push_back('{1'b0, ts[j]});
        exp_q.push_back('{1'b1, (ts != stream)});
`else
        ts = stream;
        exp_q.push_back('{1'b1, 1'b0});
`endif
        @(negedge prog_clk);
        start = 1'b1;
        first = 0;
        if (pre_valid) begin
            cfg_valid = 1'b1;
            cfg_data  = w[0];
        end
        @(negedge prog_clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_cleared_on_start", 32'(err), 32'd0);
        if (pre_valid) begin
            check("fetch_ready", 32'(cfg_ready), 32'd1);
            check("no_shift_in_fetch", 32'(ccff_shift_en), 32'd0);
            @(negedge prog_clk);
            cfg_valid = 1'b0;
            check("latency_first_shift", 32'(ccff_shift_en), 32'd1);
            first = 1;
        end
        for (int i = first; i < NW; i++) begin
            g = (gap < 0) ? int'($urandom_range(5)) : gap;
            repeat (g) @(negedge prog_clk);
            if (stray_start) begin
                start = 1'b1;
                @(negedge prog_clk);
                start = 1'b0;
            end
            feed_word(w[i]);
        end
        n = 0;
        while (!done && n < 400) begin
            @(negedge prog_clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        if (stuck_k < 0) begin
            for (int i = 0; i < CL; i++) ec[CL-1-i] = stream[i];
            check("chain_contents", 32'(chain_m), 32'(ec));
        end
        @(negedge prog_clk);
        check("idle_after_done", 32'({busy, done, ccff_shift_en}), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic interrupt_load(input logic [WW-1:0] w, input int nbits, input bit use_reset);
        int cnt;
        int k;
        for (int i = 0; i < nbits; i++) exp_q.push_back('{1'b0, w[i]});
        @(negedge prog_clk);
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = w;
        cnt = 0;
        k   = 0;
        while (cnt < nbits && k < 100) begin
            @(negedge prog_clk);
            k++;
            if (k == 1) start = 1'b0;
            if (k == 2) cfg_valid = 1'b0;
            if (ccff_shift_en) cnt++;
        end
        check("shifts_before_interrupt", 32'(cnt), 32'(nbits));
        if (use_reset) begin
            #2 pReset_n = 1'b0;
            #1;
            check("reset_mid_shift_outputs",
                  32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, err}), 32'd0);
            exp_q.delete();
            @(negedge prog_clk);
            pReset_n = 1'b1;
        end else begin
            abort = 1'b1;
            @(negedge prog_clk);
            abort = 1'b0;
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_shift_en", 32'(ccff_shift_en), 32'd0);
            repeat (3) @(negedge prog_clk);
            check("abort_no_extra", 32'({busy, done, cfg_ready}), 32'd0);
            check("abort_queue", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 pReset_n = 1'b0;
        #1;
        check("reset_outputs", 32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, err}), 32'd0);
        repeat (2) @(negedge prog_clk);
        pReset_n = 1'b1;
        @(negedge prog_clk);
        check("idle_outputs", 32'({cfg_ready, ccff_shift_en, busy, done, err}), 32'd0);

        // Two words with a 5-cycle source stall; second word contributes only 1,0,0,1.
        run_load({4'h9, 8'h3C}, 5, 1'b0, 1'b0, -1);
        run_load(12'h0A5, 0, 1'b1, 1'b0, -1);

        interrupt_load(8'hC6, 3, 1'b0);
        run_load(12'hFFF, -1, 1'b0, 1'b0, -1);

        interrupt_load(8'h6B, 2, 1'b1);
        run_load({4'h3, 8'h5A}, -1, 1'b1, 1'b0, -1);

`ifdef CCFF_READBACK_EN
        stuck_m = CL'(1) << 6;
        run_load(12'h0A5, -1, 1'b0, 1'b0, 6);
        repeat (3) @(negedge prog_clk);
        check("err_sticky", 32'(err), 32'd1);
        stuck_m = '0;
        run_load(12'h0A5, -1, 1'b1, 1'b0, -1);
        check("err_after_good_load", 32'(err), 32'd0);
`endif

        for (int t = 0; t < 16; t++) begin
            run_load(CL'($urandom), -1, 1'($urandom_range(1)), 1'($urandom_range(1)), -1);
        end

        cfg_valid = 1'b1;
        cfg_data  = 8'hAA;
        repeat (3) begin
            @(negedge prog_clk);
            check("idle_valid_ignored", 32'({cfg_ready, busy, ccff_shift_en}), 32'd0);
        end
        cfg_valid = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge prog_clk);
        check("abort_beats_start", 32'({busy, cfg_ready}), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
